// File: rtl/noc_pkg.sv
// noc_pkg: shared port codes, flit types and flit field positions for the router input side
package noc_pkg;
   localparam int FLIT_W  = 32;
   localparam int TYPE_HI = 31;
   localparam int TYPE_LO = 30;
   localparam int DX_HI   = 7;
   localparam int DX_LO   = 4;
   localparam int DY_HI   = 3;
   localparam int DY_LO   = 0;

   typedef enum logic [2:0] {
      PORT_NONE  = 3'd0,
      PORT_N     = 3'd1,
      PORT_S     = 3'd2,
      PORT_E     = 3'd3,
      PORT_W     = 3'd4,
      PORT_LOCAL = 3'd5
   } port_e;

   typedef enum logic [1:0] {
      FT_BODY   = 2'b00,
      FT_HEAD   = 2'b01,
      FT_TAIL   = 2'b10,
      FT_SINGLE = 2'b11
   } flit_type_e;
endpackage

// File: rtl/xy_route.sv
// xy_route: dimension-ordered XY output port selection, X resolved before Y
module xy_route
   import noc_pkg::*;
#(
   parameter logic [3:0] MY_X = 4'd0,
   parameter logic [3:0] MY_Y = 4'd0
) (
   input  logic [3:0] dest_x,
   input  logic [3:0] dest_y,
   output port_e      route
);
   // unsigned compares; Local only when both coordinates match
   always_comb
      route = dest_x > MY_X ? PORT_E :
              dest_x < MY_X ? PORT_W :
              dest_y > MY_Y ? PORT_N :
              dest_y < MY_Y ? PORT_S : PORT_LOCAL;
endmodule

// File: rtl/port_requester.sv
// port_requester: per-input-port packet sequencer that requests an output port and forwards flits
module port_requester
   import noc_pkg::*;
#(
   parameter logic [3:0] MY_X = 4'd0,
   parameter logic [3:0] MY_Y = 4'd0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flit_valid_i,
   input  logic [FLIT_W-1:0] flit_data_i,
   output logic              flit_pop_o,
   output logic [2:0]        req_port_addr_o,
   input  logic [2:0]        grant_port_i,
   output logic              out_valid_o,
   output logic [FLIT_W-1:0] out_data_o,
   input  logic              out_ready_i,
   output logic              err_o,
   output logic [7:0]        wait_cnt_o
);
   typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;

   state_e     state;
   port_e      route_q;
   port_e      route;
   logic       first_q;
   flit_type_e ftype;
   logic       granted;
   logic       is_start;
   logic       is_end;
   logic       stray;
   logic       bad_head;

   xy_route #(.MY_X(MY_X), .MY_Y(MY_Y)) u_route (
      .dest_x (flit_data_i[DX_HI:DX_LO]),
      .dest_y (flit_data_i[DY_HI:DY_LO]),
      .route  (route)
   );

   assign ftype    = flit_type_e'(flit_data_i[TYPE_HI:TYPE_LO]);
   assign granted  = grant_port_i == route_q;
   assign is_start = ftype == FT_HEAD || ftype == FT_SINGLE;
   assign is_end   = ftype == FT_TAIL || ftype == FT_SINGLE;
   // a body/tail at the FIFO head with no open packet is discarded
   assign stray    = state == IDLE && flit_valid_i && !is_start;
   // a head seen after the packet's first flit is demoted to body
   assign bad_head = ftype == FT_HEAD && !first_q;

   // datapath is combinational from the FIFO head; held off entirely during reset
   always_comb begin
      out_valid_o = rst_n && state == XFER && flit_valid_i && granted;
      flit_pop_o  = (out_valid_o && out_ready_i) || (rst_n && stray);
      out_data_o  = bad_head ? {FT_BODY, flit_data_i[TYPE_LO-1:0]} : flit_data_i;
   end

   // packet FSM with registered request, wait counter and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         route_q         <= PORT_NONE;
         first_q         <= 1'b0;
         wait_cnt_o      <= 8'd0;
         req_port_addr_o <= 3'd0;
         err_o           <= 1'b0;
      end else begin
         err_o <= 1'b0;
         case (state)
            IDLE:
               if (flit_valid_i && is_start) begin
                  route_q         <= route;
                  req_port_addr_o <= route;
                  wait_cnt_o      <= 8'd0;
                  state           <= REQ;
               end else if (stray) begin
                  err_o <= 1'b1;
               end
            REQ: begin
               wait_cnt_o <= wait_cnt_o == 8'hff ? wait_cnt_o : wait_cnt_o + 8'd1;
               if (granted) begin
                  first_q <= 1'b1;
                  state   <= XFER;
               end
            end
            XFER:
               if (flit_pop_o) begin
                  first_q <= 1'b0;
                  err_o   <= bad_head;
                  if (is_end) begin
                     req_port_addr_o <= 3'd0;
                     state           <= IDLE;
                  end
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_port_requester.sv
// tb_port_requester: directed checks of request, forwarding, stall, error and reset behaviour
module tb_port_requester;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flit_valid_i;
   logic [31:0] flit_data_i;
   logic        flit_pop_o;
   logic [2:0]  req_port_addr_o;
   logic [2:0]  grant_port_i;
   logic        out_valid_o;
   logic [31:0] out_data_o;
   logic        out_ready_i;
   logic        err_o;
   logic [7:0]  wait_cnt_o;

   logic [31:0] q[$];
   logic [31:0] fwd[$];
   logic        grant_en = 1'b0;
   int          err_seen = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   port_requester #(.MY_X(4'd2), .MY_Y(4'd2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flit_valid_i    (flit_valid_i),
      .flit_data_i     (flit_data_i),
      .flit_pop_o      (flit_pop_o),
      .req_port_addr_o (req_port_addr_o),
      .grant_port_i    (grant_port_i),
      .out_valid_o     (out_valid_o),
      .out_data_o      (out_data_o),
      .out_ready_i     (out_ready_i),
      .err_o           (err_o),
      .wait_cnt_o      (wait_cnt_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fl(input logic [1:0] t, input logic [7:0] id, input logic [3:0] x, input logic [3:0] y);
      return {t, 14'd0, id, x, y};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic settle();
      flit_valid_i = q.size() != 0;
      flit_data_i  = q.size() != 0 ? q[0] : 32'd0;
      grant_port_i = grant_en ? req_port_addr_o : 3'd0;
      #1;
   endtask

   task automatic tick();
      logic p;
      settle();
      p = flit_pop_o;
      if (out_valid_o && out_ready_i) fwd.push_back(out_data_o);
      if (err_o) err_seen++;
      @(posedge clk);
      #1;
      if (p && q.size() != 0) void'(q.pop_front());
      settle();
   endtask

   task automatic run_until_fwd(input int n, input int bound);
      for (int i = 0; i < bound && fwd.size() < n; i++) tick();
      check("fwd_count", fwd.size(), n);
   endtask

   initial begin
      out_ready_i = 1'b1;
      q.push_back(fl(2'b00, 8'h01, 4'd0, 4'd0));
      settle();
      check("in_rst_pop", flit_pop_o, 0);
      check("in_rst_valid", out_valid_o, 0);
      repeat (2) @(posedge clk);
      #2;
      q.delete();
      rst_n = 1'b1;
      settle();
      check("rst_req", req_port_addr_o, 0);
      check("rst_wait", wait_cnt_o, 0);
      check("rst_err", err_o, 0);

      // single flit to (5,2), granted at once
      grant_en = 1'b1;
      q.push_back(fl(2'b11, 8'h10, 4'd5, 4'd2));
      settle();
      check("t1_c0_pop", flit_pop_o, 0);
      tick();
      check("t1_c1_req", req_port_addr_o, 3);
      check("t1_c1_valid", out_valid_o, 0);
      tick();
      check("t1_c2_valid", out_valid_o, 1);
      check("t1_c2_pop", flit_pop_o, 1);
      check("t1_c2_data", out_data_o, 32'hC0001052);
      tick();
      check("t1_c3_req", req_port_addr_o, 0);
      check("t1_c3_empty", q.size(), 0);

      // local packet, grant withheld 10 cycles
      fwd.delete();
      grant_en = 1'b0;
      q.push_back(fl(2'b01, 8'h20, 4'd2, 4'd2));
      q.push_back(fl(2'b00, 8'h21, 4'd0, 4'd0));
      q.push_back(fl(2'b00, 8'h22, 4'd0, 4'd0));
      q.push_back(fl(2'b10, 8'h23, 4'd0, 4'd0));
      tick();
      check("t2_req_start", req_port_addr_o, 5);
      repeat (10) tick();
      check("t2_req_end", req_port_addr_o, 5);
      check("t2_wait", wait_cnt_o, 10);
      check("t2_nofwd", fwd.size(), 0);
      grant_en = 1'b1;
      run_until_fwd(4, 20);
      check("t2_f0", fwd.size() > 0 ? fwd[0] : 32'd0, 32'h40002022);
      check("t2_f1", fwd.size() > 1 ? fwd[1] : 32'd0, 32'h00002100);
      check("t2_f2", fwd.size() > 2 ? fwd[2] : 32'd0, 32'h00002200);
      check("t2_f3", fwd.size() > 3 ? fwd[3] : 32'd0, 32'h80002300);
      tick();
      check("t2_req_done", req_port_addr_o, 0);

      // ready stall then grant stall mid-packet, west route
      fwd.delete();
      q.push_back(fl(2'b01, 8'h30, 4'd0, 4'd0));
      for (int i = 1; i <= 3; i++) q.push_back(fl(2'b00, 8'h30 + 8'(i), 4'd0, 4'd0));
      q.push_back(fl(2'b10, 8'h34, 4'd0, 4'd0));
      run_until_fwd(1, 10);
      check("t3_req", req_port_addr_o, 4);
      out_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("t3_rdy_pop", flit_pop_o, 0);
         tick();
      end
      out_ready_i = 1'b1;
      grant_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         check("t3_gnt_valid", out_valid_o, 0);
         check("t3_gnt_pop", flit_pop_o, 0);
         check("t3_gnt_req", req_port_addr_o, 4);
         tick();
      end
      grant_en = 1'b1;
      run_until_fwd(5, 20);
      for (int i = 0; i < 5; i++)
         check("t3_order", fwd.size() > i ? fwd[i] : 32'd0, fl(i == 0 ? 2'b01 : i == 4 ? 2'b10 : 2'b00, 8'h30 + 8'(i), 4'd0, 4'd0));
      tick();

      // stray body while idle
      q.push_back(fl(2'b00, 8'h40, 4'd0, 4'd0));
      settle();
      check("t4_pop", flit_pop_o, 1);
      tick();
      check("t4_err_hi", err_o, 1);
      check("t4_req", req_port_addr_o, 0);
      check("t4_empty", q.size(), 0);
      tick();
      check("t4_err_lo", err_o, 0);

      // head inside a packet demoted to body, north route
      fwd.delete();
      err_seen = 0;
      q.push_back(fl(2'b01, 8'h50, 4'd2, 4'd5));
      q.push_back(fl(2'b01, 8'h51, 4'd3, 4'd3));
      q.push_back(fl(2'b10, 8'h52, 4'd0, 4'd0));
      tick();
      check("t5_req", req_port_addr_o, 1);
      run_until_fwd(3, 20);
      tick();
      check("t5_demoted", fwd.size() > 1 ? fwd[1] : 32'd0, 32'h00005133);
      check("t5_err_cnt", err_seen, 1);

      // wait counter saturation, south route
      grant_en = 1'b0;
      fwd.delete();
      q.push_back(fl(2'b11, 8'h60, 4'd2, 4'd0));
      tick();
      repeat (300) tick();
      check("t6_wait_sat", wait_cnt_o, 255);
      check("t6_req", req_port_addr_o, 2);
      grant_en = 1'b1;
      run_until_fwd(1, 10);
      tick();

      // reset mid-packet after two flits, east route
      fwd.delete();
      q.push_back(fl(2'b01, 8'h70, 4'd9, 4'd9));
      q.push_back(fl(2'b00, 8'h71, 4'd0, 4'd0));
      q.push_back(fl(2'b00, 8'h72, 4'd0, 4'd0));
      q.push_back(fl(2'b10, 8'h73, 4'd0, 4'd0));
      run_until_fwd(2, 20);
      check("t7_req_pre", req_port_addr_o, 3);
      rst_n = 1'b0;
      settle();
      check("t7_rst_req", req_port_addr_o, 0);
      check("t7_rst_valid", out_valid_o, 0);
      check("t7_rst_pop", flit_pop_o, 0);
      tick();
      check("t7_head_kept", q.size(), 2);
      rst_n = 1'b1;
      settle();
      check("t7_stray_pop", flit_pop_o, 1);
      tick();
      check("t7_stray_err", err_o, 1);
      check("t7_stray_req", req_port_addr_o, 0);
      for (int i = 0; i < 10 && q.size() != 0; i++) tick();
      check("t7_drained", q.size(), 0);
      check("t7_fwd_total", fwd.size(), 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
